// File: rtl/oled_i2c_responder.sv
// oled_i2c_responder: I2C target model of an SSD-class OLED controller.
// Decodes address/control/command/data bytes, tracks page/column addressing
// and emits one framebuffer write strobe per data byte. SCL is never stretched.
// Optional: define I2C_GLITCH_FILTER_EN to add a 3-sample agreement filter
// after the synchronizers; this rejects pulses of 2 CLK or less.
module oled_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       ASYNC_RST_L,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       FB_WE,
    output logic [9:0] FB_ADDR,
    output logic [7:0] FB_DATA,
    output logic       DISP_ON,
    output logic       CMD_VALID,
    output logic [7:0] CMD_BYTE
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CTRL, S_BYTE, S_IGNORE} state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   sda_pin, scl_raw, sda_raw, scl_lvl, sda_lvl;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q, byte_d;
    logic       ack_q, co_q, dc_q, sda_oe_q, fb_we_q, disp_on_q, cmd_valid_q;
    logic [2:0] page_q;
    logic [6:0] col_q;
    logic [9:0] fb_addr_q;
    logic [7:0] fb_data_q, cmd_byte_q;

    // While we pull SDA low, hold the last sampled level so our own ACK
    // can never look like a START or STOP.
    assign sda_pin = sda_oe_q ? sda_sync_q[0] : SDA_IN;
    assign scl_raw = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw = sda_sync_q[SYNC_STAGES-1];

    // Pin synchronizers; reset to the idle bus level so no edge is seen after reset.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL_IN};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_pin};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    assign scl_lvl = (scl_raw == scl_hist_q[0] && scl_raw == scl_hist_q[1]) ? scl_raw : scl_filt_q;
    assign sda_lvl = (sda_raw == sda_hist_q[0] && sda_raw == sda_hist_q[1]) ? sda_raw : sda_filt_q;

    // Agreement filter: the level moves only after 3 equal consecutive samples.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_raw};
            sda_hist_q <= {sda_hist_q[0], sda_raw};
            scl_filt_q <= scl_lvl;
            sda_filt_q <= sda_lvl;
        end
    end
`else
    assign scl_lvl = scl_raw;
    assign sda_lvl = sda_raw;
`endif

    // Edge-detect register on the conditioned bus levels.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    assign scl_rise  = scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl & scl_prev_q;
    assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;
    assign byte_d    = {shift_q[6:0], sda_lvl};

    // Protocol FSM: bit_cnt 0..7 shifts data, 8 = byte done/ACK driven, 9 = ACK clocked.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ack_q       <= 1'b0;
            co_q        <= 1'b0;
            dc_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            disp_on_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            page_q      <= '0;
            col_q       <= '0;
        end else begin
            fb_we_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                ack_q     <= 1'b0;
            end else if (stop_det) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                ack_q     <= 1'b0;
            end else if (state_q inside {S_ADDR, S_CTRL, S_BYTE}) begin
                if (scl_rise) begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_q   <= byte_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
                        bit_cnt_q <= 4'd9;
                    end
                    if (bit_cnt_q == 4'd7) begin
                        case (state_q)
                            S_ADDR: begin
                                if (byte_d[7:1] == DEV_ADDR && !byte_d[0]) begin
                                    ack_q   <= 1'b1;
                                    state_q <= S_CTRL;
                                end else begin
                                    ack_q   <= 1'b0;
                                    state_q <= S_IGNORE;
                                end
                            end
                            S_CTRL: begin
                                co_q    <= byte_d[7];
                                dc_q    <= byte_d[6];
                                ack_q   <= 1'b1;
                                state_q <= S_BYTE;
                            end
                            default: begin
                                ack_q <= 1'b1;
                                if (dc_q) begin
                                    fb_we_q   <= 1'b1;
                                    fb_addr_q <= {page_q, col_q};
                                    fb_data_q <= byte_d;
                                    col_q     <= col_q + 7'd1;
                                end else begin
                                    cmd_valid_q <= 1'b1;
                                    cmd_byte_q  <= byte_d;
                                    if (byte_d[7:4] == 4'h0)          col_q[3:0] <= byte_d[3:0];
                                    else if (byte_d[7:3] == 5'b00010) col_q[6:4] <= byte_d[2:0];
                                    else if (byte_d[7:3] == 5'b10110) page_q     <= byte_d[2:0];
                                    else if (byte_d == 8'hAF)         disp_on_q  <= 1'b1;
                                    else if (byte_d == 8'hAE)         disp_on_q  <= 1'b0;
                                end
                                if (co_q) state_q <= S_CTRL;
                            end
                        endcase
                    end
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_q <= ack_q;
                    end else if (bit_cnt_q == 4'd9) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
            end
        end
    end

    assign SDA_OE    = sda_oe_q;
    assign FB_WE     = fb_we_q;
    assign FB_ADDR   = fb_addr_q;
    assign FB_DATA   = fb_data_q;
    assign DISP_ON   = disp_on_q;
    assign CMD_VALID = cmd_valid_q;
    assign CMD_BYTE  = cmd_byte_q;

endmodule
